// File: rtl/alu_arbiter.sv
// Purpose: two-requester round-robin arbiter/sequencer in front of one shared 8-bit ALU, with a carry flag per requester.
// Latency: accept at T -> alu_enable at T+1 -> rsp_valid from T+2+ALU_LATENCY; one transaction in flight at a time.
// Backpressure: req_readyN only in IDLE; a response is held stable until its rsp_readyN, and nothing new is granted meanwhile.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/ready/op/a/b{0,1}   request handshake and operands per requester
//   rsp_valid/ready{0,1}          response handshake per requester
//   rsp_result_l/h, rsp_carry/zero/sign   captured ALU results, shared, qualified by rsp_validN
//   alu_enable/operation/op1/op2/cpu_carry   drive to the ALU
//   alu_result_l/h, alu_carry/zero/sign      results from the ALU
module alu_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req_valid0,
  output logic       req_ready0,
  input  logic [7:0] req_op0,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,

  input  logic       req_valid1,
  output logic       req_ready1,
  input  logic [7:0] req_op1,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,

  output logic       rsp_valid0,
  input  logic       rsp_ready0,
  output logic       rsp_valid1,
  input  logic       rsp_ready1,
  output logic [7:0] rsp_result_l,
  output logic [7:0] rsp_result_h,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_sign,

  output logic       alu_enable,
  output logic [7:0] alu_operation,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic       alu_cpu_carry,
  input  logic [7:0] alu_result_l,
  input  logic [7:0] alu_result_h,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign
);

  if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
    $error("alu_arbiter: ALU_LATENCY must be in 1..15");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  typedef struct packed {
    logic [7:0] result_l;
    logic [7:0] result_h;
    logic       carry;
    logic       zero;
    logic       sign;
  } rsp_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0] state_q;
  logic       gnt_q;         // requester owning the in-flight transaction
  logic       last_grant_q;  // requester served most recently
  logic [1:0] carry_q;       // private carry chain, indexed by requester
  logic [3:0] wait_cnt_q;
  logic [1:0] rsp_vld_q;     // indexed by requester
  rsp_t       rsp_q;
  req_t       drive_q;
  logic       cin_q;

  // ---------------------------------------------------------------------
  // Grant and handshake decode
  // ---------------------------------------------------------------------
  logic any_vld;
  logic gnt_sel;
  logic accept;
  logic rsp_done;
  req_t req_sel;

  always_comb begin
    any_vld = req_valid0 | req_valid1;
    // With both requesting, the one not served last wins; otherwise the lone requester.
    gnt_sel = (req_valid0 & req_valid1) ? ~last_grant_q : req_valid1;
    accept  = (state_q == ST_IDLE) & any_vld;
    req_sel = gnt_sel ? {req_op1, req_a1, req_b1} : {req_op0, req_a0, req_b0};
    // Only the owner's rsp_ready counts, and only while a response is presented.
    rsp_done = (state_q == ST_RESP) & (gnt_q ? rsp_ready1 : rsp_ready0);
  end

  assign req_ready0 = accept & ~gnt_sel;
  assign req_ready1 = accept &  gnt_sel;

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 is served first out of reset
      carry_q      <= 2'b00;
      wait_cnt_q   <= 4'd0;
      rsp_vld_q    <= 2'b00;
      rsp_q        <= '0;
      drive_q      <= '0;
      cin_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            gnt_q   <= gnt_sel;
            drive_q <= req_sel;
            cin_q   <= carry_q[gnt_sel];
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          wait_cnt_q <= LAT_LOAD;
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          // Count of 1 marks the cycle in which the ALU outputs are valid.
          if (wait_cnt_q == 4'd1) begin
            rsp_q            <= {alu_result_l, alu_result_h, alu_carry, alu_zero, alu_sign};
            rsp_vld_q[gnt_q] <= 1'b1;
            state_q          <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_done) begin
            rsp_vld_q      <= 2'b00;
            carry_q[gnt_q] <= rsp_q.carry;
            last_grant_q   <= gnt_q;
            state_q        <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign alu_enable    = (state_q == ST_ISSUE);
  assign alu_operation = drive_q.op;
  assign alu_op1       = drive_q.a;
  assign alu_op2       = drive_q.b;
  assign alu_cpu_carry = cin_q;

  assign rsp_valid0   = rsp_vld_q[0];
  assign rsp_valid1   = rsp_vld_q[1];
  assign rsp_result_l = rsp_q.result_l;
  assign rsp_result_h = rsp_q.result_h;
  assign rsp_carry    = rsp_q.carry;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_sign     = rsp_q.sign;

  // ---------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    !(req_ready0 && req_ready1));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid0 && rsp_valid1));
  a_enable_pulse: assert property (@(posedge clk) disable iff (rst)
    alu_enable |=> !alu_enable);

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: directed self-checking bench for alu_arbiter at ALU_LATENCY 1 and 3.
// Latency: each instance drives a behavioural ALU whose results appear ALU_LATENCY cycles after enable.
// Backpressure: rsp_ready is held low for several cycles on one transaction.
module tb_alu_arbiter;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_ADC = 8'h01;

  typedef struct packed {
    logic [7:0] l;
    logic [7:0] h;
    logic       c;
    logic       z;
    logic       s;
  } alu_res_t;

  // Presented whenever the ALU has no fresh result, so a mistimed capture shows up.
  localparam alu_res_t POISON = {8'hEE, 8'hEE, 3'b111};

  logic clk;
  logic rst;

  // Instance with ALU_LATENCY = 1
  logic       req_valid0, req_ready0, req_valid1, req_ready1;
  logic [7:0] req_op0, req_a0, req_b0, req_op1, req_a1, req_b1;
  logic       rsp_valid0, rsp_ready0, rsp_valid1, rsp_ready1;
  logic [7:0] rsp_result_l, rsp_result_h;
  logic       rsp_carry, rsp_zero, rsp_sign;
  logic       alu_enable, alu_cpu_carry;
  logic [7:0] alu_operation, alu_op1, alu_op2;
  logic [7:0] alu_result_l, alu_result_h;
  logic       alu_carry, alu_zero, alu_sign;

  // Instance with ALU_LATENCY = 3
  logic       l3_req_valid0, l3_req_ready0, l3_req_valid1, l3_req_ready1;
  logic [7:0] l3_req_op0, l3_req_a0, l3_req_b0, l3_req_op1, l3_req_a1, l3_req_b1;
  logic       l3_rsp_valid0, l3_rsp_ready0, l3_rsp_valid1, l3_rsp_ready1;
  logic [7:0] l3_rsp_result_l, l3_rsp_result_h;
  logic       l3_rsp_carry, l3_rsp_zero, l3_rsp_sign;
  logic       l3_alu_enable, l3_alu_cpu_carry;
  logic [7:0] l3_alu_operation, l3_alu_op1, l3_alu_op2;
  logic [7:0] l3_alu_result_l, l3_alu_result_h;
  logic       l3_alu_carry, l3_alu_zero, l3_alu_sign;

  int n_chk;
  int n_err;

  // Round-robin table: transaction k is issued by requester k%2.
  logic [7:0] rr_a   [4] = '{8'hF0, 8'h03, 8'h01, 8'h05};
  logic [7:0] rr_b   [4] = '{8'h20, 8'h04, 8'h02, 8'h05};
  logic [7:0] rr_l   [4] = '{8'h10, 8'h07, 8'h04, 8'h0A};
  logic       rr_c   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic       rr_cin [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  alu_arbiter #(.ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_ready0(req_ready0), .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
    .req_valid1(req_valid1), .req_ready1(req_ready1), .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid0(rsp_valid0), .rsp_ready0(rsp_ready0), .rsp_valid1(rsp_valid1), .rsp_ready1(rsp_ready1),
    .rsp_result_l(rsp_result_l), .rsp_result_h(rsp_result_h),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
    .alu_enable(alu_enable), .alu_operation(alu_operation), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_cpu_carry(alu_cpu_carry), .alu_result_l(alu_result_l), .alu_result_h(alu_result_h),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign)
  );

  alu_arbiter #(.ALU_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst),
    .req_valid0(l3_req_valid0), .req_ready0(l3_req_ready0), .req_op0(l3_req_op0), .req_a0(l3_req_a0), .req_b0(l3_req_b0),
    .req_valid1(l3_req_valid1), .req_ready1(l3_req_ready1), .req_op1(l3_req_op1), .req_a1(l3_req_a1), .req_b1(l3_req_b1),
    .rsp_valid0(l3_rsp_valid0), .rsp_ready0(l3_rsp_ready0), .rsp_valid1(l3_rsp_valid1), .rsp_ready1(l3_rsp_ready1),
    .rsp_result_l(l3_rsp_result_l), .rsp_result_h(l3_rsp_result_h),
    .rsp_carry(l3_rsp_carry), .rsp_zero(l3_rsp_zero), .rsp_sign(l3_rsp_sign),
    .alu_enable(l3_alu_enable), .alu_operation(l3_alu_operation), .alu_op1(l3_alu_op1), .alu_op2(l3_alu_op2),
    .alu_cpu_carry(l3_alu_cpu_carry), .alu_result_l(l3_alu_result_l), .alu_result_h(l3_alu_result_h),
    .alu_carry(l3_alu_carry), .alu_zero(l3_alu_zero), .alu_sign(l3_alu_sign)
  );

  // Behavioural ALU: ADD / ADC, result_h carries the ninth sum bit.
  function automatic alu_res_t alu_fn(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic cin);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? {8'd0, cin} : 9'd0);
    alu_fn = {sum[7:0], {7'd0, sum[8]}, sum[8], (sum[7:0] == 8'd0), sum[7]};
  endfunction

  alu_res_t alu1_q;
  alu_res_t alu3_q [3];

  always @(posedge clk) begin
    alu1_q <= alu_enable ? alu_fn(alu_operation, alu_op1, alu_op2, alu_cpu_carry) : POISON;
    alu3_q[0] <= l3_alu_enable ? alu_fn(l3_alu_operation, l3_alu_op1, l3_alu_op2, l3_alu_cpu_carry) : POISON;
    alu3_q[1] <= alu3_q[0];
    alu3_q[2] <= alu3_q[1];
  end

  assign {alu_result_l, alu_result_h, alu_carry, alu_zero, alu_sign} = alu1_q;
  assign {l3_alu_result_l, l3_alu_result_h, l3_alu_carry, l3_alu_zero, l3_alu_sign} = alu3_q[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start of a cycle: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the latency-1 instance with rsp_ready held high.
  task automatic txn(input string tag, input bit id, input logic [7:0] op,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_l,
                     input bit exp_c, input bit exp_z, input bit exp_s, input bit exp_cin);
    int k;
    cyc();
    if (id) begin
      req_valid1 = 1'b1; req_op1 = op; req_a1 = a; req_b1 = b; rsp_ready1 = 1'b1;
    end else begin
      req_valid0 = 1'b1; req_op0 = op; req_a0 = a; req_b0 = b; rsp_ready0 = 1'b1;
    end
    k = 0;
    @(negedge clk);
    while (!(id ? req_ready1 : req_ready0) && k < 20) begin
      cyc(); @(negedge clk); k++;
    end
    chk({tag, ".rdy"}, id ? req_ready1 : req_ready0, 1);
    chk({tag, ".rdy_other"}, id ? req_ready0 : req_ready1, 0);
    cyc();
    if (id) req_valid1 = 1'b0; else req_valid0 = 1'b0;
    @(negedge clk);
    chk({tag, ".en"}, alu_enable, 1);
    chk({tag, ".drive"}, {alu_operation, alu_op1, alu_op2}, {op, a, b});
    chk({tag, ".cin"}, alu_cpu_carry, exp_cin);
    k = 1;
    while (!(id ? rsp_valid1 : rsp_valid0) && k < 20) begin
      cyc(); @(negedge clk); k++;
    end
    chk({tag, ".lat"}, k, 3);
    chk({tag, ".res"}, {rsp_result_l, rsp_result_h, rsp_carry, rsp_zero, rsp_sign},
        {exp_l, 7'd0, exp_c, exp_c, exp_z, exp_s});
    cyc(); @(negedge clk);
    chk({tag, ".rsp_drop"}, id ? rsp_valid1 : rsp_valid0, 0);
    rsp_ready0 = 1'b0;
    rsp_ready1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  g;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    {req_valid0, req_valid1, rsp_ready0, rsp_ready1} = '0;
    {req_op0, req_a0, req_b0, req_op1, req_a1, req_b1} = '0;
    {l3_req_valid0, l3_req_valid1, l3_rsp_ready0, l3_rsp_ready1} = '0;
    {l3_req_op0, l3_req_a0, l3_req_b0, l3_req_op1, l3_req_a1, l3_req_b1} = '0;

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk("reset.ctl", {req_ready0, req_ready1, rsp_valid0, rsp_valid1, alu_enable, alu_cpu_carry}, 0);
    chk("reset.drive", {alu_operation, alu_op1, alu_op2}, 0);
    chk("reset.rsp", {rsp_result_l, rsp_result_h, rsp_carry, rsp_zero, rsp_sign}, 0);
    rst = 1'b0;

    // Single op, then per-requester carry chains
    txn("single", 1'b0, OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    txn("c.add0", 1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    txn("c.add1", 1'b1, OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    txn("c.adc0", 1'b0, OP_ADC, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1);
    txn("c.add0b", 1'b0, OP_ADD, 8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    txn("c.add1b", 1'b1, OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset while in WAIT: both carry chains are 1 at this point
    cyc();
    req_valid0 = 1'b1; req_op0 = OP_ADC; req_a0 = 8'h55; req_b0 = 8'h01; rsp_ready0 = 1'b1;
    @(negedge clk);
    chk("rst.acc", req_ready0, 1);
    cyc();
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("rst.cin_before", alu_cpu_carry, 1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ctl", {req_ready0, req_ready1, rsp_valid0, rsp_valid1, alu_enable, alu_cpu_carry}, 0);
    chk("rst.drive", {alu_operation, alu_op1, alu_op2}, 0);
    chk("rst.rsp", {rsp_result_l, rsp_result_h, rsp_carry, rsp_zero, rsp_sign}, 0);
    repeat (3) begin
      cyc(); @(negedge clk);
      chk("rst.no_rsp", {rsp_valid0, rsp_valid1}, 0);
    end
    rsp_ready0 = 1'b0;

    // Round-robin with both requesters continuously valid; carry chains start cleared
    cyc();
    req_valid0 = 1'b1; req_op0 = OP_ADC; req_a0 = rr_a[0]; req_b0 = rr_b[0];
    req_valid1 = 1'b1; req_op1 = OP_ADC; req_a1 = rr_a[1]; req_b1 = rr_b[1];
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      n = 0;
      @(negedge clk);
      while (!(req_ready0 | req_ready1) && n < 20) begin
        cyc(); @(negedge clk); n++;
      end
      chk("rr.gnt", {req_ready1, req_ready0}, g ? 2'b10 : 2'b01);
      cyc();
      if (k + 2 < 4) begin
        if (g) begin req_a1 = rr_a[k+2]; req_b1 = rr_b[k+2]; end
        else   begin req_a0 = rr_a[k+2]; req_b0 = rr_b[k+2]; end
      end else begin
        if (g) req_valid1 = 1'b0; else req_valid0 = 1'b0;
      end
      @(negedge clk);
      chk("rr.cin", alu_cpu_carry, rr_cin[k]);
      chk("rr.op1", alu_op1, rr_a[k]);
      n = 1;
      while (!(rsp_valid0 | rsp_valid1) && n < 20) begin
        chk("rr.quiet", {req_ready0, req_ready1}, 0);
        cyc(); @(negedge clk); n++;
      end
      chk("rr.lat", n, 3);
      chk("rr.rsp_id", {rsp_valid1, rsp_valid0}, g ? 2'b10 : 2'b01);
      chk("rr.rdy_in_resp", {req_ready0, req_ready1}, 0);
      chk("rr.res", {rsp_result_l, rsp_carry}, {rr_l[k], rr_c[k]});
      cyc();
    end

    // Response backpressure on requester 1 while requester 0 waits
    req_valid1 = 1'b1; req_op1 = OP_ADD; req_a1 = 8'h22; req_b1 = 8'h11;
    rsp_ready1 = 1'b0; rsp_ready0 = 1'b1;
    @(negedge clk);
    chk("bp.acc", req_ready1, 1);
    cyc();
    req_valid1 = 1'b0;
    req_valid0 = 1'b1; req_op0 = OP_ADD; req_a0 = 8'h01; req_b0 = 8'h01;
    n = 0;
    @(negedge clk);
    while (!rsp_valid1 && n < 20) begin
      chk("bp.wait_rdy0", req_ready0, 0);
      cyc(); @(negedge clk); n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp.vld", {rsp_valid1, rsp_valid0}, 2'b10);
      chk("bp.dat", {rsp_result_l, rsp_result_h, rsp_carry, rsp_zero, rsp_sign}, {8'h33, 8'h00, 3'b000});
      chk("bp.rdy0", req_ready0, 0);
      chk("bp.op1", alu_op1, 8'h22);
      cyc(); @(negedge clk);
    end
    rsp_ready1 = 1'b1;
    chk("bp.vld_last", rsp_valid1, 1);
    chk("bp.rdy0_last", req_ready0, 0);
    cyc(); @(negedge clk);
    chk("bp.regrant", req_ready0, 1);
    chk("bp.rsp_drop", rsp_valid1, 0);
    cyc();
    req_valid0 = 1'b0; rsp_ready1 = 1'b0;
    @(negedge clk);
    chk("bp.cin", alu_cpu_carry, 0);
    chk("bp.op1b", alu_op1, 8'h01);
    n = 1;
    while (!rsp_valid0 && n < 20) begin
      cyc(); @(negedge clk); n++;
    end
    chk("bp.lat0", n, 3);
    chk("bp.res0", rsp_result_l, 8'h02);
    cyc();
    rsp_ready0 = 1'b0;

    // ALU_LATENCY = 3 instance
    l3_req_valid0 = 1'b1; l3_req_op0 = OP_ADD; l3_req_a0 = 8'h7F; l3_req_b0 = 8'h01;
    l3_rsp_ready0 = 1'b1;
    @(negedge clk);
    chk("l3.acc", {l3_req_ready1, l3_req_ready0}, 2'b01);
    cyc();
    l3_req_valid0 = 1'b0;
    @(negedge clk);
    chk("l3.en", l3_alu_enable, 1);
    n = 1;
    while (!l3_rsp_valid0 && n < 20) begin
      cyc(); @(negedge clk); n++;
      chk("l3.en_once", l3_alu_enable, 0);
    end
    chk("l3.lat", n, 5);
    chk("l3.res", {l3_rsp_result_l, l3_rsp_result_h, l3_rsp_carry, l3_rsp_zero, l3_rsp_sign},
        {8'h80, 8'h00, 3'b001});
    cyc(); @(negedge clk);
    chk("l3.drop", l3_rsp_valid0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
